// File: rtl/shift_add_mult_param.sv
// -----------------------------------------------------------------------------
// shift_add_mult_param
//
// Sequential shift-and-add multiplier with WIDTH-bit operands and a 2*WIDTH-bit
// registered product. Each operation is either unsigned or two's complement.
// One partial-product iteration runs per clock. Operands are converted to
// magnitudes when they are latched, multiplied as unsigned values, and the sign
// is applied once at the end.
//
// Ports:
//   clk          system clock, rising-edge active
//   n_rst        asynchronous active-low reset
//   start        request pulse; accepted only while busy=0 (IDLE or DONE)
//   signed_mode  1 = two's complement operands, 0 = unsigned; sampled with start
//   M            multiplicand, sampled with start
//   Q            multiplier, sampled with start
//   busy         high while an iteration sequence is running (CALC)
//   done         one-cycle pulse in the cycle after P is updated
//   P            product register; holds the last result
//   state_dbg    current FSM state (IDLE=0, CALC=1, DONE=2)
//
// Handshake: start is a request with no acknowledge other than busy. It is
// sampled on a rising edge only when busy=0, and this includes the DONE cycle,
// so results can be produced back to back. A start seen while busy=1 is
// dropped. done rises on the same edge that loads P and falls one edge later.
// -----------------------------------------------------------------------------
module shift_add_mult_param #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     M,
    input  logic [WIDTH-1:0]     Q,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   P,
    output logic [1:0]           state_dbg
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state;
    logic [WIDTH-1:0]   mr;
    logic [WIDTH-1:0]   qr;
    logic [WIDTH-1:0]   a;
    logic               carry;
    logic [CW-1:0]      cnt;
    logic               neg;

    // Next-iteration datapath
    logic [WIDTH:0]     add_sum;
    logic [WIDTH-1:0]   a_shift;
    logic [WIDTH-1:0]   qr_shift;
    logic [2*WIDTH-1:0] prod_mag;
    logic [2*WIDTH-1:0] prod_res;
    logic               load;

    // Magnitude of an operand. In signed mode the most negative value negates
    // to itself, and that bit pattern is exactly 2^(WIDTH-1) read as unsigned.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                   input logic             sm);
        return (sm && x[WIDTH-1]) ? -x : x;
    endfunction

    assign busy      = (state == S_CALC);
    assign state_dbg = state;

    // A new operation may start from IDLE or from the one-cycle DONE state.
    assign load = start && (state != S_CALC);

    always_comb begin
        add_sum  = {carry, a};
        if (qr[0]) begin
            add_sum = {1'b0, a} + {1'b0, mr};
        end
        // Right shift of {carry, A, Qr} with zero shifted in. The carry lands
        // in the MSB of A, and the new carry is always zero.
        a_shift  = add_sum[WIDTH:1];
        qr_shift = {add_sum[0], qr[WIDTH-1:1]};
        prod_mag = {a_shift, qr_shift};
        prod_res = neg ? -prod_mag : prod_mag;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= S_IDLE;
            mr    <= '0;
            qr    <= '0;
            a     <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            neg   <= 1'b0;
            done  <= 1'b0;
            P     <= '0;
        end else begin
            done <= 1'b0;
            if (load) begin
                mr    <= magnitude(M, signed_mode);
                qr    <= magnitude(Q, signed_mode);
                a     <= '0;
                carry <= 1'b0;
                cnt   <= CW'(WIDTH);
                neg   <= signed_mode & (M[WIDTH-1] ^ Q[WIDTH-1]);
                state <= S_CALC;
            end else begin
                case (state)
                    S_CALC: begin
                        a     <= a_shift;
                        qr    <= qr_shift;
                        carry <= 1'b0;
                        cnt   <= cnt - CW'(1);
                        if (cnt == CW'(1)) begin
                            // Final iteration: the product comes from the
                            // post-shift values computed this cycle.
                            P     <= prod_res;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                    default: begin
                        // IDLE without start, or DONE without start.
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_shift_add_mult_param.sv
module tb_shift_add_mult_param;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic n_rst = 1'b0;
    always #5 clk = ~clk;

    // WIDTH=4 instance
    logic       start4 = 1'b0, sm4 = 1'b0;
    logic [3:0] m4 = '0, q4 = '0;
    logic       busy4, done4;
    logic [7:0] p4;
    logic [1:0] st4;

    // WIDTH=8 instance
    logic       start8 = 1'b0, sm8 = 1'b0;
    logic [7:0] m8 = '0, q8 = '0;
    logic       busy8, done8;
    logic [15:0] p8;
    logic [1:0] st8;

    shift_add_mult_param #(.WIDTH(4)) dut4 (
        .clk(clk), .n_rst(n_rst), .start(start4), .signed_mode(sm4),
        .M(m4), .Q(q4), .busy(busy4), .done(done4), .P(p4), .state_dbg(st4)
    );

    shift_add_mult_param #(.WIDTH(8)) dut8 (
        .clk(clk), .n_rst(n_rst), .start(start8), .signed_mode(sm8),
        .M(m8), .Q(q8), .busy(busy8), .done(done8), .P(p8), .state_dbg(st8)
    );

    // Selected-instance view used by the shared tasks
    bit          sel8 = 1'b0;
    logic        cur_busy, cur_done;
    logic [15:0] cur_p;
    assign cur_busy = sel8 ? busy8 : busy4;
    assign cur_done = sel8 ? done8 : done4;
    assign cur_p    = sel8 ? p8 : {8'h00, p4};

    // ---------------- scoreboard ----------------
    logic [15:0] exp_q[$];
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Drive one start pulse and return #1 after the accepting edge.
    task automatic launch(input string tag, input bit s8, input logic sm,
                          input logic [7:0] m, input logic [7:0] q,
                          input logic [15:0] exp);
        sel8 = s8;
        exp_q.push_back(exp);
        @(negedge clk);
        if (s8) begin
            start8 = 1'b1; sm8 = sm; m8 = m; q8 = q;
        end else begin
            start4 = 1'b1; sm4 = sm; m4 = m[3:0]; q4 = q[3:0];
        end
        @(posedge clk);
        #1;
        start4 = 1'b0;
        start8 = 1'b0;
        check({tag, "_busy_start"}, cur_busy, 1'b1);
    endtask

    // Wait (bounded) for done, then check latency, product and busy.
    task automatic wait_done(input string tag, input int exp_edges);
        int edges = 0;
        logic [15:0] exp;
        while (!cur_done && edges < 50) begin
            @(posedge clk);
            #1;
            edges++;
        end
        exp = exp_q.pop_front();
        if (!cur_done) begin
            check({tag, "_timeout"}, 1'b0, 1'b1);
        end else begin
            check({tag, "_lat"}, edges, exp_edges);
            check({tag, "_p"}, cur_p, exp);
            check({tag, "_busy_end"}, cur_busy, 1'b0);
        end
    endtask

    task automatic do_op(input string tag, input bit s8, input logic sm,
                         input logic [7:0] m, input logic [7:0] q,
                         input logic [15:0] exp);
        launch(tag, s8, sm, m, q, exp);
        wait_done(tag, s8 ? 8 : 4);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int spur;

        // Reset state
        #13;
        check("rst_busy4", busy4, 1'b0);
        check("rst_done4", done4, 1'b0);
        check("rst_p4", p4, 8'h00);
        check("rst_state4", st4, 2'd0);
        check("rst_p8", p8, 16'h0000);
        @(negedge clk);
        n_rst = 1'b1;
        repeat (2) @(posedge clk);

        // 1. unsigned
        do_op("u_11x6", 0, 1'b0, 8'h0B, 8'h06, 16'h0042);
        do_op("u_3x11", 0, 1'b0, 8'h03, 8'h0B, 16'h0021);

        // 2. signed
        do_op("s_m5x6",  0, 1'b1, 8'h0B, 8'h06, 16'h00E2);
        do_op("s_m8xm8", 0, 1'b1, 8'h08, 8'h08, 16'h0040);
        do_op("s_m1x1",  0, 1'b1, 8'h0F, 8'h01, 16'h00FF);

        // 3. corners
        do_op("u_0x9",   0, 1'b0, 8'h00, 8'h09, 16'h0000);
        do_op("u_7x0",   0, 1'b0, 8'h07, 8'h00, 16'h0000);
        do_op("u_15x15", 0, 1'b0, 8'h0F, 8'h0F, 16'h00E1);
        repeat (3) @(posedge clk);
        #1;
        check("hold_p", p4, 8'hE1);
        check("hold_busy", busy4, 1'b0);

        // 4a. start during CALC is ignored
        launch("ign", 0, 1'b0, 8'h04, 8'h03, 16'h000C);
        @(negedge clk);
        start4 = 1'b1; m4 = 4'hF; q4 = 4'hF; sm4 = 1'b1;
        @(posedge clk);
        #1;
        start4 = 1'b0;
        check("ign_busy_mid", busy4, 1'b1);
        check("ign_p_mid", p4, 8'hE1);
        wait_done("ign", 3);

        // 4b. start in the DONE cycle: no idle gap
        start4 = 1'b1; sm4 = 1'b0; m4 = 4'h2; q4 = 4'h3;
        exp_q.push_back(16'h0006);
        @(posedge clk);
        #1;
        start4 = 1'b0;
        check("b2b_busy", busy4, 1'b1);
        check("b2b_done_low", done4, 1'b0);
        check("b2b_p_hold", p4, 8'h0C);
        wait_done("b2b", 4);

        // 5. reset mid-operation
        launch("rstmid", 0, 1'b0, 8'h07, 8'h07, 16'h0031);
        void'(exp_q.pop_back());
        @(posedge clk);
        @(negedge clk);
        n_rst = 1'b0;
        #1;
        check("rstmid_busy", busy4, 1'b0);
        check("rstmid_done", done4, 1'b0);
        check("rstmid_p", p4, 8'h00);
        @(negedge clk);
        n_rst = 1'b1;
        spur = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (done4 || busy4) spur++;
        end
        check("rstmid_spurious", spur, 0);
        check("rstmid_p_after", p4, 8'h00);
        do_op("u_5x5", 0, 1'b0, 8'h05, 8'h05, 16'h0019);

        // 6. WIDTH=8 instance
        do_op("w8_255x255", 1, 1'b0, 8'hFF, 8'hFF, 16'hFE01);
        do_op("w8_m128x127", 1, 1'b1, 8'h80, 8'h7F, 16'hC080);
        do_op("w8_m128xm128", 1, 1'b1, 8'h80, 8'h80, 16'h4000);

        // ---------------- report ----------------
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global guard so the run always terminates
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
